// File: rtl/reg_file_scoreboard.sv
// rtl/reg_file_scoreboard.sv - dual-write register file with pending-load scoreboard (optional REGFILE_BYPASS_EN forwarding)
module reg_file_scoreboard #(
   parameter int W       = 8,
   parameter int A       = 4,
   parameter int ZERO_R0 = 0
) (
   input  logic         Clk,
   input  logic         ResetN,
   input  logic [A-1:0] RaddrA,
   input  logic [A-1:0] RaddrB,
   output logic [W-1:0] DataOutA,
   output logic [W-1:0] DataOutB,
   output logic         BusyA,
   output logic         BusyB,
   input  logic         WriteEn0,
   input  logic [A-1:0] Waddr0,
   input  logic [W-1:0] DataIn0,
   input  logic         WriteEn1,
   input  logic [A-1:0] Waddr1,
   input  logic [W-1:0] DataIn1,
   input  logic         PendSet,
   input  logic [A-1:0] PendAddr,
   output logic         CollisionErr,
   output logic         DoubleSetErr
);

   localparam int DEPTH = 1 << A;
   localparam bit HARD_ZERO = (ZERO_R0 != 0);

   logic [W-1:0]     regs [DEPTH];
   logic [DEPTH-1:0] busy;

   logic we0;
   logic we1;
   logic pend;
   logic collide;
   logic double_set;
   logic zero_a;
   logic zero_b;

   // Qualify every request; a hardwired r0 swallows writes, clears and sets to address 0
   always_comb begin
      we0        = WriteEn0 && !(HARD_ZERO && (Waddr0 == '0));
      we1        = WriteEn1 && !(HARD_ZERO && (Waddr1 == '0));
      pend       = PendSet  && !(HARD_ZERO && (PendAddr == '0));
      zero_a     = HARD_ZERO && (RaddrA == '0);
      zero_b     = HARD_ZERO && (RaddrB == '0);
      collide    = we0 && we1 && (Waddr0 == Waddr1);
      // A set is only a double set if the load return is not freeing that register this cycle
      double_set = pend && busy[PendAddr] && !(we1 && (Waddr1 == PendAddr));
   end

   // Register storage: load-return port has priority on an address collision
   always_ff @(posedge Clk or negedge ResetN) begin
      if (!ResetN) begin
         regs <= '{default: '0};
      end else begin
         if (we0 && !collide) regs[Waddr0] <= DataIn0;
         if (we1)             regs[Waddr1] <= DataIn1;
      end
   end

   // Scoreboard: clear from load return first, then set from load issue so a same-cycle set wins
   always_ff @(posedge Clk or negedge ResetN) begin
      if (!ResetN) begin
         busy <= '0;
      end else begin
         if (we1)  busy[Waddr1]   <= 1'b0;
         if (pend) busy[PendAddr] <= 1'b1;
      end
   end

   // Error flags: collision is a per-edge pulse, double set is sticky until reset
   always_ff @(posedge Clk or negedge ResetN) begin
      if (!ResetN) begin
         CollisionErr <= 1'b0;
         DoubleSetErr <= 1'b0;
      end else begin
         CollisionErr <= collide;
         if (double_set) DoubleSetErr <= 1'b1;
      end
   end

   // Read ports: stored value, optionally forwarded from this cycle's writes; forced to zero in reset or on hard r0
   always_comb begin
      DataOutA = regs[RaddrA];
      DataOutB = regs[RaddrB];
      BusyA    = busy[RaddrA];
      BusyB    = busy[RaddrB];
`ifdef REGFILE_BYPASS_EN
      if (we0 && (Waddr0 == RaddrA)) DataOutA = DataIn0;
      if (we0 && (Waddr0 == RaddrB)) DataOutB = DataIn0;
      if (we1 && (Waddr1 == RaddrA)) begin
         DataOutA = DataIn1;
         BusyA    = 1'b0;
      end
      if (we1 && (Waddr1 == RaddrB)) begin
         DataOutB = DataIn1;
         BusyB    = 1'b0;
      end
`endif
      if (!ResetN || zero_a) begin
         DataOutA = '0;
         BusyA    = 1'b0;
      end
      if (!ResetN || zero_b) begin
         DataOutB = '0;
         BusyB    = 1'b0;
      end
   end

endmodule

// File: tb/tb_reg_file_scoreboard.sv
// tb/tb_reg_file_scoreboard.sv - self-checking bench for reg_file_scoreboard (ZERO_R0=0 and ZERO_R0=1 instances)
module tb_reg_file_scoreboard;

   logic       Clk;
   logic       ResetN;
   logic [3:0] RaddrA, RaddrB, Waddr0, Waddr1, PendAddr;
   logic [7:0] DataIn0, DataIn1;
   logic       WriteEn0, WriteEn1, PendSet;

   logic [7:0] data_a [2];
   logic [7:0] data_b [2];
   logic       busy_a [2];
   logic       busy_b [2];
   logic       coll_o [2];
   logic       dse_o  [2];

   int checks = 0;
   int errors = 0;

   // Reference state: index 0 is the plain file, index 1 has r0 hardwired
   logic [7:0] mem [2][16];
   bit         bsy [2][16];
   bit         coll [2];
   bit         dse [2];

   reg_file_scoreboard #(.W(8), .A(4), .ZERO_R0(0)) dut (
      .Clk(Clk), .ResetN(ResetN), .RaddrA(RaddrA), .RaddrB(RaddrB),
      .DataOutA(data_a[0]), .DataOutB(data_b[0]), .BusyA(busy_a[0]), .BusyB(busy_b[0]),
      .WriteEn0(WriteEn0), .Waddr0(Waddr0), .DataIn0(DataIn0),
      .WriteEn1(WriteEn1), .Waddr1(Waddr1), .DataIn1(DataIn1),
      .PendSet(PendSet), .PendAddr(PendAddr),
      .CollisionErr(coll_o[0]), .DoubleSetErr(dse_o[0])
   );

   reg_file_scoreboard #(.W(8), .A(4), .ZERO_R0(1)) dut_z (
      .Clk(Clk), .ResetN(ResetN), .RaddrA(RaddrA), .RaddrB(RaddrB),
      .DataOutA(data_a[1]), .DataOutB(data_b[1]), .BusyA(busy_a[1]), .BusyB(busy_b[1]),
      .WriteEn0(WriteEn0), .Waddr0(Waddr0), .DataIn0(DataIn0),
      .WriteEn1(WriteEn1), .Waddr1(Waddr1), .DataIn1(DataIn1),
      .PendSet(PendSet), .PendAddr(PendAddr),
      .CollisionErr(coll_o[1]), .DoubleSetErr(dse_o[1])
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   function automatic bit okz(int z, logic [3:0] a);
      return !(z == 1 && a == 4'd0);
   endfunction

   function automatic logic [7:0] exp_data(int z, logic [3:0] a);
      logic [7:0] d;
      if (!ResetN || !okz(z, a)) return 8'h00;
      d = mem[z][a];
`ifdef REGFILE_BYPASS_EN
      if (WriteEn0 && Waddr0 == a) d = DataIn0;
      if (WriteEn1 && Waddr1 == a) d = DataIn1;
`endif
      return d;
   endfunction

   function automatic bit exp_busy(int z, logic [3:0] a);
      bit b;
      if (!ResetN || !okz(z, a)) return 1'b0;
      b = bsy[z][a];
`ifdef REGFILE_BYPASS_EN
      if (WriteEn1 && Waddr1 == a) b = 1'b0;
`endif
      return b;
   endfunction

   task automatic model_reset();
      for (int z = 0; z < 2; z++) begin
         for (int i = 0; i < 16; i++) begin
            mem[z][i] = 8'h00;
            bsy[z][i] = 1'b0;
         end
         coll[z] = 1'b0;
         dse[z]  = 1'b0;
      end
   endtask

   task automatic model_edge();
      for (int z = 0; z < 2; z++) begin
         bit w0, w1, p;
         if (ResetN) begin
            w0 = WriteEn0 && okz(z, Waddr0);
            w1 = WriteEn1 && okz(z, Waddr1);
            p  = PendSet && okz(z, PendAddr);
            if (p && bsy[z][PendAddr] && !(w1 && Waddr1 == PendAddr)) dse[z] = 1'b1;
            coll[z] = w0 && w1 && (Waddr0 == Waddr1);
            if (w0) mem[z][Waddr0] = DataIn0;
            if (w1) mem[z][Waddr1] = DataIn1;
            if (w1) bsy[z][Waddr1] = 1'b0;
            if (p)  bsy[z][PendAddr] = 1'b1;
         end
      end
   endtask

   task automatic idle();
      WriteEn0 = 0; WriteEn1 = 0; PendSet = 0;
      Waddr0 = 0; Waddr1 = 0; PendAddr = 0; DataIn0 = 0; DataIn1 = 0;
   endtask

   task automatic tick();
      @(posedge Clk);
      model_edge();
      #1;
   endtask

   task automatic pulse_reset();
      #1 ResetN = 1'b0;
      model_reset();
      #1 ResetN = 1'b1;
   endtask

   task automatic test_reset();
      ResetN = 1'b0; RaddrA = 0; RaddrB = 0;
      idle();
      model_reset();
      repeat (2) @(posedge Clk);
      #1;
      for (int i = 0; i < 16; i++) begin
         RaddrA = i[3:0]; RaddrB = 4'(15 - i);
         #1;
         for (int z = 0; z < 2; z++) begin
            checks++;
            if (data_a[z] !== 8'h00 || busy_a[z] !== 1'b0 || data_b[z] !== 8'h00 || busy_b[z] !== 1'b0) begin
               errors++;
               $display("FAIL reset_read z=%0d addr=%0d got da=%h ba=%b db=%h bb=%b required 0", z, i, data_a[z], busy_a[z], data_b[z], busy_b[z]);
            end
         end
      end
      ResetN = 1'b1;
      @(negedge Clk);
      WriteEn0 = 1; Waddr0 = 3; DataIn0 = 8'hA5; PendSet = 1; PendAddr = 3;
      tick();
      // pending writes to r3 are discarded by a reset between edges
      WriteEn0 = 1; Waddr0 = 3; DataIn0 = 8'h77; WriteEn1 = 1; Waddr1 = 3; DataIn1 = 8'h78;
      RaddrA = 3;
      #1 ResetN = 1'b0;
      model_reset();
      #1;
      for (int z = 0; z < 2; z++) begin
         checks++;
         if (data_a[z] !== 8'h00 || busy_a[z] !== 1'b0 || coll_o[z] !== 1'b0 || dse_o[z] !== 1'b0) begin
            errors++;
            $display("FAIL reset_async z=%0d got da=%h ba=%b ce=%b dse=%b required 0", z, data_a[z], busy_a[z], coll_o[z], dse_o[z]);
         end
      end
      idle();
      #1 ResetN = 1'b1;
      tick();
      WriteEn0 = 1; Waddr0 = 3; DataIn0 = 8'h3C;
      tick();
      idle();
      #1;
      for (int z = 0; z < 2; z++) begin
         checks++;
         if (data_a[z] !== 8'h3C || busy_a[z] !== 1'b0) begin
            errors++;
            $display("FAIL reset_first_write z=%0d got da=%h ba=%b required 3c 0", z, data_a[z], busy_a[z]);
         end
      end
   endtask

   task automatic test_dual_write();
      RaddrA = 2; RaddrB = 5;
      WriteEn0 = 1; Waddr0 = 2; DataIn0 = 8'h11;
      WriteEn1 = 1; Waddr1 = 5; DataIn1 = 8'h22;
      #1;
      for (int z = 0; z < 2; z++) begin
         checks++;
         if (data_a[z] !== exp_data(z, 2) || data_b[z] !== exp_data(z, 5)) begin
            errors++;
            $display("FAIL dual_same_cycle z=%0d got a=%h b=%h required %h %h", z, data_a[z], data_b[z], exp_data(z, 2), exp_data(z, 5));
         end
      end
      tick();
      idle();
      #1;
      for (int z = 0; z < 2; z++) begin
         checks++;
         if (data_a[z] !== 8'h11 || data_b[z] !== 8'h22 || coll_o[z] !== 1'b0) begin
            errors++;
            $display("FAIL dual_write z=%0d got a=%h b=%h ce=%b required 11 22 0", z, data_a[z], data_b[z], coll_o[z]);
         end
      end
   endtask

   task automatic test_collision();
      RaddrA = 7;
      WriteEn0 = 1; Waddr0 = 7; DataIn0 = 8'h33;
      WriteEn1 = 1; Waddr1 = 7; DataIn1 = 8'h44;
      tick();
      idle();
      #1;
      for (int z = 0; z < 2; z++) begin
         checks++;
         if (data_a[z] !== 8'h44 || coll_o[z] !== 1'b1) begin
            errors++;
            $display("FAIL collision z=%0d got r7=%h ce=%b required 44 1", z, data_a[z], coll_o[z]);
         end
      end
      tick();
      for (int z = 0; z < 2; z++) begin
         checks++;
         if (coll_o[z] !== 1'b0) begin
            errors++;
            $display("FAIL collision_pulse z=%0d got ce=%b required 0", z, coll_o[z]);
         end
      end
   endtask

   task automatic test_back_to_back();
      WriteEn0 = 1; Waddr0 = 9; DataIn0 = 8'h01;
      WriteEn1 = 1; Waddr1 = 9; DataIn1 = 8'h02;
      for (int n = 0; n < 2; n++) begin
         tick();
         for (int z = 0; z < 2; z++) begin
            checks++;
            if (coll_o[z] !== 1'b1) begin
               errors++;
               $display("FAIL b2b_collision z=%0d n=%0d got ce=%b required 1", z, n, coll_o[z]);
            end
         end
      end
      idle();
      tick();
      for (int z = 0; z < 2; z++) begin
         checks++;
         if (coll_o[z] !== 1'b0) begin
            errors++;
            $display("FAIL b2b_release z=%0d got ce=%b required 0", z, coll_o[z]);
         end
      end
   endtask

   task automatic test_scoreboard();
      bit eb;
      RaddrA = 4;
      PendSet = 1; PendAddr = 4;
      tick();
      idle();
      #1;
      for (int z = 0; z < 2; z++) begin
         checks++;
         if (busy_a[z] !== 1'b1 || dse_o[z] !== 1'b0) begin
            errors++;
            $display("FAIL sb_set z=%0d got busy=%b dse=%b required 1 0", z, busy_a[z], dse_o[z]);
         end
      end
      WriteEn1 = 1; Waddr1 = 4; DataIn1 = 8'h5A; PendSet = 1; PendAddr = 4;
      tick();
      idle();
      #1;
      for (int z = 0; z < 2; z++) begin
         checks++;
         if (busy_a[z] !== 1'b1 || dse_o[z] !== 1'b0 || data_a[z] !== 8'h5A) begin
            errors++;
            $display("FAIL sb_clear_then_set z=%0d got busy=%b dse=%b d=%h required 1 0 5a", z, busy_a[z], dse_o[z], data_a[z]);
         end
      end
      WriteEn1 = 1; Waddr1 = 4; DataIn1 = 8'h6B;
`ifdef REGFILE_BYPASS_EN
      eb = 1'b0;
`else
      eb = 1'b1;
`endif
      #1;
      for (int z = 0; z < 2; z++) begin
         checks++;
         if (busy_a[z] !== eb) begin
            errors++;
            $display("FAIL sb_clear_same_cycle z=%0d got busy=%b required %b", z, busy_a[z], eb);
         end
      end
      tick();
      idle();
      #1;
      for (int z = 0; z < 2; z++) begin
         checks++;
         if (busy_a[z] !== 1'b0) begin
            errors++;
            $display("FAIL sb_clear z=%0d got busy=%b required 0", z, busy_a[z]);
         end
      end
      PendSet = 1; PendAddr = 4;
      tick();
      tick();
      idle();
      tick();
      for (int z = 0; z < 2; z++) begin
         checks++;
         if (dse_o[z] !== 1'b1 || busy_a[z] !== 1'b1) begin
            errors++;
            $display("FAIL sb_double_set z=%0d got dse=%b busy=%b required 1 1", z, dse_o[z], busy_a[z]);
         end
      end
   endtask

   task automatic test_bypass();
      logic [7:0] e;
      RaddrA = 6;
      WriteEn0 = 1; Waddr0 = 6; DataIn0 = 8'h10;
      tick();
      WriteEn0 = 1; Waddr0 = 6; DataIn0 = 8'h9C;
`ifdef REGFILE_BYPASS_EN
      e = 8'h9C;
`else
      e = 8'h10;
`endif
      #1;
      for (int z = 0; z < 2; z++) begin
         checks++;
         if (data_a[z] !== e) begin
            errors++;
            $display("FAIL bypass_same_cycle z=%0d got %h required %h", z, data_a[z], e);
         end
      end
      tick();
      idle();
      #1;
      for (int z = 0; z < 2; z++) begin
         checks++;
         if (data_a[z] !== 8'h9C) begin
            errors++;
            $display("FAIL bypass_next_cycle z=%0d got %h required 9c", z, data_a[z]);
         end
      end
   endtask

   task automatic test_zero_r0();
      pulse_reset();
      RaddrA = 0; RaddrB = 0;
      WriteEn0 = 1; Waddr0 = 0; DataIn0 = 8'hFF;
      WriteEn1 = 1; Waddr1 = 0; DataIn1 = 8'hEE;
      PendSet = 1; PendAddr = 0;
      #1;
      checks++;
      if (data_a[1] !== 8'h00 || busy_a[1] !== 1'b0) begin
         errors++;
         $display("FAIL zero_r0_bypass got d=%h busy=%b required 00 0", data_a[1], busy_a[1]);
      end
      tick();
      tick();
      idle();
      #1;
      checks++;
      if (data_a[1] !== 8'h00 || busy_a[1] !== 1'b0 || coll_o[1] !== 1'b0 || dse_o[1] !== 1'b0) begin
         errors++;
         $display("FAIL zero_r0 got d=%h busy=%b ce=%b dse=%b required 00 0 0 0", data_a[1], busy_a[1], coll_o[1], dse_o[1]);
      end
      checks++;
      if (data_a[0] !== 8'hEE || busy_a[0] !== 1'b1 || coll_o[0] !== 1'b1 || dse_o[0] !== 1'b0) begin
         errors++;
         $display("FAIL plain_r0 got d=%h busy=%b ce=%b dse=%b required ee 1 1 0", data_a[0], busy_a[0], coll_o[0], dse_o[0]);
      end
   endtask

   function automatic logic [3:0] rand_addr();
      if ($urandom_range(0, 1) == 0) return 4'($urandom_range(0, 3));
      return 4'($urandom_range(0, 15));
   endfunction

   task automatic test_random();
      pulse_reset();
      for (int cyc = 0; cyc < 400; cyc++) begin
         if (cyc == 200) pulse_reset();
         RaddrA   = rand_addr();
         RaddrB   = rand_addr();
         WriteEn0 = ($urandom_range(0, 1) == 1);
         WriteEn1 = ($urandom_range(0, 2) == 0);
         PendSet  = ($urandom_range(0, 3) == 0);
         Waddr0   = rand_addr();
         Waddr1   = rand_addr();
         PendAddr = rand_addr();
         DataIn0  = 8'($urandom);
         DataIn1  = 8'($urandom);
         #1;
         for (int z = 0; z < 2; z++) begin
            checks++;
            if (data_a[z] !== exp_data(z, RaddrA) || busy_a[z] !== exp_busy(z, RaddrA)) begin
               errors++;
               $display("FAIL rand_port_a z=%0d cyc=%0d addr=%0d got d=%h b=%b required %h %b", z, cyc, RaddrA, data_a[z], busy_a[z], exp_data(z, RaddrA), exp_busy(z, RaddrA));
            end
            checks++;
            if (data_b[z] !== exp_data(z, RaddrB) || busy_b[z] !== exp_busy(z, RaddrB)) begin
               errors++;
               $display("FAIL rand_port_b z=%0d cyc=%0d addr=%0d got d=%h b=%b required %h %b", z, cyc, RaddrB, data_b[z], busy_b[z], exp_data(z, RaddrB), exp_busy(z, RaddrB));
            end
         end
         tick();
         for (int z = 0; z < 2; z++) begin
            checks++;
            if (coll_o[z] !== coll[z] || dse_o[z] !== dse[z]) begin
               errors++;
               $display("FAIL rand_flags z=%0d cyc=%0d got ce=%b dse=%b required %b %b", z, cyc, coll_o[z], dse_o[z], coll[z], dse[z]);
            end
         end
      end
      idle();
   endtask

   initial begin
      test_reset();
      test_dual_write();
      test_collision();
      test_back_to_back();
      test_scoreboard();
      test_bypass();
      test_zero_r0();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout after 200000 time units");
      $fatal(1);
   end

endmodule
